// File: rtl/noc_run_ctrl.sv
// Run sequencer for the 2x2 mesh traffic-generator array: flush, arm, run, drain, done.
// Optional macro NOC_RUN_CTRL_STAGGER_EN staggers start_out over four cycles, one PE per cycle.
module noc_run_ctrl #(
    parameter int TIMEOUT_W    = 16,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 abort,
    input  logic                 cfg_mode,
    input  logic [3:0]           cfg_rate,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic [3:0]           send_finish,
    input  logic [3:0]           receive_finish,
    output logic                 enable_wire,
    output logic                 mode_wire,
    output logic [3:0]           rate_wire,
    output logic                 flush_wire,
    output logic [3:0]           start_in,
    output logic [3:0]           start_out,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [31:0]          run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_ARM_RX, S_ARM_TX, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [3:0]             rate_q, rate_d;
    logic [TIMEOUT_W-1:0]   tmo_lim_q, tmo_lim_d;
    logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [3:0]             snd_q, snd_d;
    logic [3:0]             rcv_q, rcv_d;
    logic [7:0]             flush_cnt_q, flush_cnt_d;
    logic [31:0]            run_cycles_q, run_cycles_d;
    logic                   timeout_err_q, timeout_err_d;
`ifdef NOC_RUN_CTRL_STAGGER_EN
    logic [1:0]             stg_q, stg_d;
`endif

    logic                   enable_q, enable_d;
    logic                   mode_wire_q, mode_wire_d;
    logic [3:0]             rate_wire_q, rate_wire_d;
    logic                   flush_q, flush_d;
    logic [3:0]             start_in_q, start_in_d;
    logic [3:0]             start_out_q, start_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [3:0]             snd_acc, rcv_acc;
    logic [TIMEOUT_W-1:0]   tmo_inc;
    logic                   tmo_hit;
    logic [31:0]            run_inc;

    assign snd_acc = snd_q | send_finish;
    assign rcv_acc = rcv_q | receive_finish;
    assign tmo_inc = tmo_cnt_q + 1'b1;
    // tmo_inc counts the current cycle, so a limit of L allows exactly L RUN/DRAIN cycles.
    assign tmo_hit = (tmo_lim_q != '0) && (tmo_inc == tmo_lim_q);
    assign run_inc = (run_cycles_q == 32'hFFFF_FFFF) ? run_cycles_q : run_cycles_q + 32'd1;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        rate_d        = rate_q;
        tmo_lim_d     = tmo_lim_q;
        tmo_cnt_d     = tmo_cnt_q;
        snd_d         = snd_q;
        rcv_d         = rcv_q;
        flush_cnt_d   = flush_cnt_q;
        run_cycles_d  = run_cycles_q;
        timeout_err_d = timeout_err_q;
`ifdef NOC_RUN_CTRL_STAGGER_EN
        stg_d         = stg_q;
`endif
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go && !abort) begin
                        state_d       = S_FLUSH;
                        mode_d        = cfg_mode;
                        rate_d        = cfg_rate;
                        tmo_lim_d     = cfg_timeout;
                        tmo_cnt_d     = '0;
                        snd_d         = 4'h0;
                        rcv_d         = 4'h0;
                        run_cycles_d  = 32'd0;
                        timeout_err_d = 1'b0;
                        flush_cnt_d   = 8'(FLUSH_CYCLES - 1);
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q == 8'd0) begin
                        state_d = S_ARM_RX;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 8'd1;
                    end
                end
                S_ARM_RX: begin
                    state_d = S_ARM_TX;
`ifdef NOC_RUN_CTRL_STAGGER_EN
                    stg_d   = 2'd0;
`endif
                end
                S_ARM_TX: begin
`ifdef NOC_RUN_CTRL_STAGGER_EN
                    if (stg_q == 2'd3) begin
                        state_d = S_RUN;
                    end else begin
                        stg_d = stg_q + 2'd1;
                    end
`else
                    state_d = S_RUN;
`endif
                end
                S_RUN: begin
                    snd_d        = snd_acc;
                    rcv_d        = rcv_acc;
                    tmo_cnt_d    = tmo_inc;
                    run_cycles_d = run_inc;
                    if (snd_acc == 4'hF) begin
                        state_d = S_DRAIN;
                    end else if (tmo_hit) begin
                        state_d       = S_DONE;
                        timeout_err_d = 1'b1;
                    end
                end
                S_DRAIN: begin
                    rcv_d        = rcv_acc;
                    tmo_cnt_d    = tmo_inc;
                    run_cycles_d = run_inc;
                    if (rcv_acc == 4'hF) begin
                        state_d = S_DONE;
                    end else if (tmo_hit) begin
                        state_d       = S_DONE;
                        timeout_err_d = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        flush_d     = (state_d == S_FLUSH);
        start_in_d  = (state_d == S_ARM_RX) ? 4'hF : 4'h0;
        enable_d    = (state_d == S_ARM_TX) || (state_d == S_RUN) || (state_d == S_DRAIN);
        mode_wire_d = busy_d ? mode_d : 1'b0;
        rate_wire_d = busy_d ? rate_d : 4'h0;
`ifdef NOC_RUN_CTRL_STAGGER_EN
        start_out_d = (state_d == S_ARM_TX) ? (4'b0001 << stg_d) : 4'h0;
`else
        start_out_d = (state_d == S_ARM_TX) ? 4'hF : 4'h0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            rate_q        <= 4'h0;
            tmo_lim_q     <= '0;
            tmo_cnt_q     <= '0;
            snd_q         <= 4'h0;
            rcv_q         <= 4'h0;
            flush_cnt_q   <= 8'd0;
            run_cycles_q  <= 32'd0;
            timeout_err_q <= 1'b0;
`ifdef NOC_RUN_CTRL_STAGGER_EN
            stg_q         <= 2'd0;
`endif
            enable_q      <= 1'b0;
            mode_wire_q   <= 1'b0;
            rate_wire_q   <= 4'h0;
            flush_q       <= 1'b0;
            start_in_q    <= 4'h0;
            start_out_q   <= 4'h0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            rate_q        <= rate_d;
            tmo_lim_q     <= tmo_lim_d;
            tmo_cnt_q     <= tmo_cnt_d;
            snd_q         <= snd_d;
            rcv_q         <= rcv_d;
            flush_cnt_q   <= flush_cnt_d;
            run_cycles_q  <= run_cycles_d;
            timeout_err_q <= timeout_err_d;
`ifdef NOC_RUN_CTRL_STAGGER_EN
            stg_q         <= stg_d;
`endif
            enable_q      <= enable_d;
            mode_wire_q   <= mode_wire_d;
            rate_wire_q   <= rate_wire_d;
            flush_q       <= flush_d;
            start_in_q    <= start_in_d;
            start_out_q   <= start_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign enable_wire = enable_q;
    assign mode_wire   = mode_wire_q;
    assign rate_wire   = rate_wire_q;
    assign flush_wire  = flush_q;
    assign start_in    = start_in_q;
    assign start_out   = start_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_noc_run_ctrl.sv
// Directed bench for noc_run_ctrl; cycle c counts clock edges after the one that samples go.
// Expected timings follow NOC_RUN_CTRL_STAGGER_EN when defined.
module tb_noc_run_ctrl;

    localparam int FLUSH = 8;
`ifdef NOC_RUN_CTRL_STAGGER_EN
    localparam int TX = 4;
`else
    localparam int TX = 1;
`endif
    // FLUSH in cycles 1..8, ARM_RX at 9, ARM_TX from 10, first RUN cycle below.
    localparam int RUN1 = FLUSH + 2 + TX;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go, abort, cfg_mode;
    logic [3:0]  cfg_rate;
    logic [15:0] cfg_timeout;
    logic [3:0]  send_finish, receive_finish;
    logic        enable_wire, mode_wire, flush_wire, busy, done, timeout_err;
    logic [3:0]  rate_wire, start_in, start_out;
    logic [31:0] run_cycles;

    int errors = 0;
    int checks = 0;

    noc_run_ctrl #(.TIMEOUT_W(16), .FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_rate(cfg_rate), .cfg_timeout(cfg_timeout),
        .send_finish(send_finish), .receive_finish(receive_finish),
        .enable_wire(enable_wire), .mode_wire(mode_wire), .rate_wire(rate_wire),
        .flush_wire(flush_wire), .start_in(start_in), .start_out(start_out),
        .busy(busy), .done(done), .timeout_err(timeout_err), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        go = 1'b0; abort = 1'b0; cfg_mode = 1'b0; cfg_rate = 4'h0;
        cfg_timeout = 16'd0; send_finish = 4'h0; receive_finish = 4'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({enable_wire, mode_wire, rate_wire, flush_wire, busy, done, timeout_err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0", {enable_wire, mode_wire, rate_wire, flush_wire, busy, done, timeout_err});
        end
        checks++;
        if ({start_in, start_out} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes: got %h want 00", {start_in, start_out});
        end
        checks++;
        if (run_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_run_cycles: got %0d want 0", run_cycles);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_run();
        int flush_n = 0, flush_first = -1, sin_n = 0, sin_at = -1, sout_n = 0;
        int en_first = -1, done_n = 0, done_at = -1, rc_done = -1;
        logic terr_done = 1'bx, busy_after = 1'bx, mode_after = 1'bx, mode_c1 = 1'bx;
        logic [3:0] rate_c1 = 4'hx, sin_val = 4'h0;
        logic [3:0] so[4];
        logic [3:0] exp_so[4];
`ifdef NOC_RUN_CTRL_STAGGER_EN
        exp_so[0] = 4'b0001; exp_so[1] = 4'b0010; exp_so[2] = 4'b0100; exp_so[3] = 4'b1000;
`else
        exp_so[0] = 4'hF; exp_so[1] = 4'h0; exp_so[2] = 4'h0; exp_so[3] = 4'h0;
`endif
        cfg_mode = 1'b1; cfg_rate = 4'hA; cfg_timeout = 16'd0;
        checks++;
        if ({mode_wire, rate_wire} !== 5'd0) begin
            errors++;
            $display("FAIL idle_cfg_outputs: got %b want 0", {mode_wire, rate_wire});
        end
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            int r;
            r = c - RUN1 + 1;
            send_finish    = (r >= 20) ? 4'hF : 4'h0;
            receive_finish = (r >= 30) ? 4'hF : 4'h0;
            if (flush_wire) begin
                flush_n++;
                if (flush_first < 0) flush_first = c;
            end
            if (start_in != 4'h0) begin sin_n++; sin_at = c; sin_val = start_in; end
            if (start_out != 4'h0) sout_n++;
            if (c >= 10 && c <= 13) so[c-10] = start_out;
            if (enable_wire && en_first < 0) en_first = c;
            if (c == 1) begin mode_c1 = mode_wire; rate_c1 = rate_wire; end
            if (done) begin done_n++; done_at = c; rc_done = int'(run_cycles); terr_done = timeout_err; end
            if (done_at > 0 && c == done_at + 1) begin busy_after = busy; mode_after = mode_wire; end
            step();
        end
        send_finish = 4'h0; receive_finish = 4'h0;
        checks++;
        if (flush_n != FLUSH || flush_first != 1) begin
            errors++;
            $display("FAIL basic_flush: got %0d cycles from %0d want %0d from 1", flush_n, flush_first, FLUSH);
        end
        checks++;
        if (sin_n != 1 || sin_at != FLUSH + 1 || sin_val !== 4'hF) begin
            errors++;
            $display("FAIL basic_start_in: got n=%0d at=%0d val=%h want n=1 at=%0d val=f", sin_n, sin_at, sin_val, FLUSH + 1);
        end
        checks++;
        if (sout_n != TX) begin
            errors++;
            $display("FAIL basic_start_out_count: got %0d want %0d", sout_n, TX);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (so[i] !== exp_so[i]) begin
                errors++;
                $display("FAIL basic_start_out_%0d: got %b want %b", i, so[i], exp_so[i]);
            end
        end
        checks++;
        if (en_first != FLUSH + 2) begin
            errors++;
            $display("FAIL basic_enable_first: got %0d want %0d", en_first, FLUSH + 2);
        end
        checks++;
        if (mode_c1 !== 1'b1 || rate_c1 !== 4'hA) begin
            errors++;
            $display("FAIL basic_cfg_latched: got mode=%b rate=%h want 1 a", mode_c1, rate_c1);
        end
        checks++;
        if (done_n != 1 || done_at != RUN1 + 30) begin
            errors++;
            $display("FAIL basic_done: got n=%0d at=%0d want n=1 at=%0d", done_n, done_at, RUN1 + 30);
        end
        checks++;
        if (rc_done != 30 || terr_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_counts: got run_cycles=%0d terr=%b want 30 0", rc_done, terr_done);
        end
        checks++;
        if (busy_after !== 1'b0 || mode_after !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: got busy=%b mode=%b want 0 0", busy_after, mode_after);
        end
    endtask

    task automatic test_timeout();
        int done_n = 0, done_at = -1, rc_done = -1;
        logic terr_pre = 1'bx, terr_done = 1'bx;
        cfg_timeout = 16'd50;
        send_finish = 4'b0111;
        receive_finish = 4'hF;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c == RUN1 + 49) terr_pre = timeout_err;
            if (done) begin done_n++; done_at = c; rc_done = int'(run_cycles); terr_done = timeout_err; end
            step();
        end
        send_finish = 4'h0; receive_finish = 4'h0;
        checks++;
        if (done_n != 1 || done_at != RUN1 + 50) begin
            errors++;
            $display("FAIL timeout_done: got n=%0d at=%0d want n=1 at=%0d", done_n, done_at, RUN1 + 50);
        end
        checks++;
        if (terr_pre !== 1'b0 || terr_done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: got pre=%b at_done=%b want 0 1", terr_pre, terr_done);
        end
        checks++;
        if (rc_done != 50) begin
            errors++;
            $display("FAIL timeout_run_cycles: got %0d want 50", rc_done);
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got terr=%b busy=%b want 1 0", timeout_err, busy);
        end
        cfg_timeout = 16'd0;
        go = 1'b1;
        step();
        go = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear_on_go: got terr=%b busy=%b want 0 1", timeout_err, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || flush_wire !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_flush: got busy=%b flush=%b want 0 0", busy, flush_wire);
        end
    endtask

    task automatic test_abort_restart();
        int done_n = 0, done_at = -1, rc_done = -1;
        logic en_pre;
        cfg_timeout = 16'd0;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= RUN1 + 1; c++) begin
            int r;
            r = c - RUN1 + 1;
            send_finish    = (r == 1) ? 4'b0011 : 4'h0;
            receive_finish = (r == 1) ? 4'b0101 : 4'h0;
            step();
        end
        send_finish = 4'h0; receive_finish = 4'h0;
        en_pre = enable_wire;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (en_pre !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_enable: got %b want 1", en_pre);
        end
        checks++;
        if ({busy, enable_wire, done, start_in, start_out} !== 11'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %b want 0", {busy, enable_wire, done, start_in, start_out});
        end
        for (int c = 0; c < 5; c++) begin
            if (done) done_n++;
            step();
        end
        checks++;
        if (done_n != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses want 0", done_n);
        end
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= RUN1 + 50; c++) begin
            int r;
            r = c - RUN1 + 1;
            send_finish    = (r == 3) ? 4'b1100 : (r == 30) ? 4'b0011 : 4'h0;
            receive_finish = (r == 5) ? 4'b1010 : (r == 40) ? 4'b0101 : 4'h0;
            if (done) begin done_n++; done_at = c; rc_done = int'(run_cycles); end
            step();
        end
        send_finish = 4'h0; receive_finish = 4'h0;
        checks++;
        if (done_n != 1 || done_at != RUN1 + 40 || rc_done != 40) begin
            errors++;
            $display("FAIL restart_cleared_seen: got n=%0d at=%0d rc=%0d want n=1 at=%0d rc=40", done_n, done_at, rc_done, RUN1 + 40);
        end
    endtask

    task automatic test_pulses();
        int done_n = 0, done_at = -1, rc_done = -1, en_last = -1;
        cfg_timeout = 16'd0;
        go = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            int r;
            r = c - RUN1 + 1;
            case (r)
                2:       send_finish = 4'b0001;
                5:       send_finish = 4'b0010;
                9:       send_finish = 4'b0100;
                12:      send_finish = 4'b1000;
                default: send_finish = 4'h0;
            endcase
            case (r)
                7:       receive_finish = 4'b1000;
                14:      receive_finish = 4'b0001;
                16:      receive_finish = 4'b0010;
                18:      receive_finish = 4'b0100;
                default: receive_finish = 4'h0;
            endcase
            if (enable_wire) en_last = c;
            if (done) begin done_n++; done_at = c; rc_done = int'(run_cycles); end
            step();
        end
        send_finish = 4'h0; receive_finish = 4'h0;
        checks++;
        if (done_n != 1 || done_at != RUN1 + 18) begin
            errors++;
            $display("FAIL pulses_done: got n=%0d at=%0d want n=1 at=%0d", done_n, done_at, RUN1 + 18);
        end
        checks++;
        if (rc_done != 18 || en_last != RUN1 + 17) begin
            errors++;
            $display("FAIL pulses_counts: got rc=%0d en_last=%0d want 18 %0d", rc_done, en_last, RUN1 + 17);
        end
    endtask

    task automatic test_back_to_back();
        int sin_n = 0, done_at = -1, rc_done = -1;
        logic busy_idle = 1'bx;
        cfg_timeout = 16'd0;
        cfg_mode = 1'b1;
        send_finish = 4'hF;
        receive_finish = 4'hF;
        go = 1'b1;
        step();
        for (int c = 1; c <= RUN1 + 3; c++) begin
            if (start_in != 4'h0) sin_n++;
            if (done) begin done_at = c; rc_done = int'(run_cycles); end
            if (c == RUN1 + 3) begin
                busy_idle = busy;
                send_finish = 4'h0;
                receive_finish = 4'h0;
            end
            step();
        end
        checks++;
        if (sin_n != 1 || done_at != RUN1 + 2 || rc_done != 2) begin
            errors++;
            $display("FAIL b2b_fast_finish: got sin=%0d done_at=%0d rc=%0d want 1 %0d 2", sin_n, done_at, rc_done, RUN1 + 2);
        end
        checks++;
        if (busy_idle !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: got busy=%b want 0", busy_idle);
        end
        checks++;
        if (busy !== 1'b1 || flush_wire !== 1'b1) begin
            errors++;
            $display("FAIL b2b_held_go_restart: got busy=%b flush=%b want 1 1", busy, flush_wire);
        end
        for (int k = 2; k <= RUN1 + 2; k++) step();
        checks++;
        if (enable_wire !== 1'b1) begin
            errors++;
            $display("FAIL b2b_in_run: got enable=%b want 1", enable_wire);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({enable_wire, mode_wire, busy, flush_wire, done, timeout_err} !== 6'd0 || run_cycles !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got %b rc=%0d want 0 0", {enable_wire, mode_wire, busy, flush_wire, done, timeout_err}, run_cycles);
        end
        go = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_timeout();
        test_abort_restart();
        test_pulses();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_run_ctrl.md
# noc_run_ctrl

Run sequencer for the 2x2 mesh traffic-generator array. It takes a single `go` request and drives the shared PE control wires (`enable_wire`, `mode_wire`, `rate_wire`, `flush_wire`) and the per-PE `start_in` / `start_out` strobes in a fixed order. It then collects each PE's send- and receive-finish indications and reports run completion, timeout and elapsed cycles. It sits above the four PEs and four routers, replacing free-running top-level control pins with one sequenced controller.

## Interface
Parameters:
- `TIMEOUT_W`, default 16: width of the timeout limit and counter.
- `FLUSH_CYCLES`, default 8: number of cycles `flush_wire` is held high; range 1..255.

Ports (bit index of every 4-bit PE vector: 0=PE00, 1=PE01, 2=PE10, 3=PE11):
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `go` in 1: start request, sampled in IDLE only.
- `abort` in 1: cancels a run.
- `cfg_mode` in 1: latched at `go`.
- `cfg_rate` in 4: latched at `go`.
- `cfg_timeout` in TIMEOUT_W: latched at `go`; a value of 0 disables the timeout.
- `send_finish` in 4: per-PE `task_send_finish_lc`, level or pulse.
- `receive_finish` in 4: per-PE `task_receive_finish_lc`, level or pulse.
- `enable_wire` out 1
- `mode_wire` out 1
- `rate_wire` out 4
- `flush_wire` out 1
- `start_in` out 4
- `start_out` out 4
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `timeout_err` out 1: sticky; cleared at the next accepted `go`.
- `run_cycles` out 32: cycles spent in RUN plus DRAIN; saturates at all-ones.

## Operation
States: IDLE, FLUSH, ARM_RX, ARM_TX, RUN, DRAIN, DONE.

- **IDLE**
  - All strobes are 0.
  - On `go`=1 and `abort`=0: latch the cfg inputs, clear the sticky finish registers, clear `run_cycles` and `timeout_err`, and load the flush counter. Next state is FLUSH.
- **FLUSH**
  - `flush_wire`=1 for exactly FLUSH_CYCLES cycles, then go to ARM_RX.
- **ARM_RX**
  - `start_in`=4'hF for one cycle, then go to ARM_TX.
- **ARM_TX**
  - `enable_wire`=1 and `start_out`=4'hF for one cycle, then go to RUN.
- **RUN**
  - `enable_wire`=1.
  - `snd_seen |= send_finish` every cycle.
  - When `snd_seen`==4'hF, go to DRAIN.
- **DRAIN**
  - `enable_wire`=1.
  - `rcv_seen |= receive_finish` every cycle. `rcv_seen` also accumulates during RUN.
  - When `rcv_seen`==4'hF, go to DONE.
- **DONE**
  - `done`=1 for one cycle, `enable_wire`=0, then go to IDLE.

Timeout and cycle counting:
- The timeout counter runs in RUN and DRAIN.
- When `cfg_timeout`!=0 and the counter equals `cfg_timeout`, set `timeout_err` and go to DONE.
- `run_cycles` increments every RUN/DRAIN cycle and saturates at 32'hFFFFFFFF.

Abort and ignored inputs:
- `abort`=1 in any state other than IDLE forces IDLE on the next edge: all strobes drop and no `done` is produced. `abort` has priority over every other transition.
- `go` outside IDLE is ignored.
- `mode_wire` and `rate_wire` output the latched values while `busy`=1, and 0 in IDLE.

Simultaneous events:
- If the finish condition and the timeout condition hit in the same cycle, the finish wins and `timeout_err` stays 0.
- If all send and receive finishes are already seen on entry to RUN, the sequence is RUN→DRAIN→DONE, one cycle each.

## Timing
- Reset values:
  - All outputs 0; `run_cycles`=0; state is IDLE.
- Sequence after `go` is sampled high on edge N:
  - FLUSH occupies cycles N+1 .. N+FLUSH_CYCLES.
  - `start_in` is high at N+FLUSH_CYCLES+1.
  - `start_out` and the first `enable_wire` are high at N+FLUSH_CYCLES+2.
- A finish condition met in cycle M produces the state change at M+1. `done` is high in the cycle after the DRAIN exit.
- `busy` rises one cycle after `go` is sampled and falls one cycle after `done`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
`NOC_RUN_CTRL_STAGGER_EN`:
- **Defined:** ARM_TX lasts 4 cycles and asserts one `start_out` bit per cycle in the order PE00, PE01, PE10, PE11. `enable_wire` is high from the first of these cycles.
- **Undefined:** the single-cycle 4'hF strobe described under Operation.

## Test plan
- `FLUSH_CYCLES`=8, `go` pulse, each PE asserts `send_finish` after 20 cycles and `receive_finish` after 30 cycles → `flush_wire` high exactly 8 cycles, `start_in` 1 cycle, `start_out` 1 cycle, `done` 1 cycle, `timeout_err`=0, `run_cycles`≈30.
- `cfg_timeout`=50, PE11 never asserts send finish → `timeout_err`=1 and `done` after 50 RUN cycles; `timeout_err` clears at the next `go`.
- `abort` asserted in RUN → IDLE next cycle, `enable_wire`=0, no `done`; a subsequent `go` restarts with cleared `rcv_seen`/`snd_seen`.
- Finish signals given as one-cycle pulses at different times, plus a pulse of `receive_finish` that arrives before the matching send finish → sticky capture; `done` is produced only after all 8 finishes are seen.
- `go` held high through a whole run and `rst_n` dropped mid-RUN → no second run triggers while `busy`; reset forces all outputs to 0 asynchronously. With `NOC_RUN_CTRL_STAGGER_EN`: `start_out` reads 0001, 0010, 0100, 1000 on consecutive cycles.
